// File: rtl/reg_file_8x16.sv
// reg_file_8x16: 8 x 16-bit register file with one synchronous write port,
// two combinational read ports (A, B), direct per-register outputs q0..q7
// that feed the downstream 8-to-1 operand mux, and a clear sequencer that
// zeroes one register per cycle on request.
//
// Optional feature: define REG_BYPASS_EN to forward an accepted write onto
// read ports A/B in the same cycle when the read address matches. q0..q7
// always show stored contents.
module reg_file_8x16 #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             clr_req,
    output logic             busy,
    input  logic [AW-1:0]    rd_addr_a,
    output logic [WIDTH-1:0] rd_data_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_b,
    output logic [WIDTH-1:0] q0,
    output logic [WIDTH-1:0] q1,
    output logic [WIDTH-1:0] q2,
    output logic [WIDTH-1:0] q3,
    output logic [WIDTH-1:0] q4,
    output logic [WIDTH-1:0] q5,
    output logic [WIDTH-1:0] q6,
    output logic [WIDTH-1:0] q7
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [AW-1:0]    r_clr_cnt;
    logic [AW-1:0]    w_clr_cnt_nxt;
    logic             w_busy;
    logic             w_wr_commit;
    logic [WIDTH-1:0] r_regs [DEPTH];

    // Sequencer state and clear pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    // Next-state, clear pointer and busy decode; clr_req is ignored outside IDLE.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        w_busy        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (clr_req) begin
                    w_state_nxt   = ST_CLEAR;
                    w_clr_cnt_nxt = '0;
                end
            end
            ST_CLEAR: begin
                w_busy = 1'b1;
                if (r_clr_cnt == AW'(DEPTH - 1)) begin
                    w_state_nxt   = ST_IDLE;
                    w_clr_cnt_nxt = '0;
                end else begin
                    w_clr_cnt_nxt = r_clr_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_clr_cnt_nxt = '0;
            end
        endcase
    end

    // A write is accepted only in IDLE; writes during CLEAR are dropped.
    always_comb begin
        w_wr_commit = wr_en && (r_state == ST_IDLE);
    end

    // Register storage: clear slot has priority while sequencing, else the write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (r_state == ST_CLEAR) begin
            r_regs[r_clr_cnt] <= '0;
        end else if (w_wr_commit) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

`ifdef REG_BYPASS_EN
    logic w_fwd_a;
    logic w_fwd_b;

    // Forwarding is also gated by rst_n so every output reads 0 during reset.
    always_comb begin
        w_fwd_a   = w_wr_commit && rst_n && (rd_addr_a == wr_addr);
        w_fwd_b   = w_wr_commit && rst_n && (rd_addr_b == wr_addr);
        rd_data_a = w_fwd_a ? wr_data : r_regs[rd_addr_a];
        rd_data_b = w_fwd_b ? wr_data : r_regs[rd_addr_b];
    end
`else
    // Read ports show stored contents only.
    always_comb begin
        rd_data_a = r_regs[rd_addr_a];
        rd_data_b = r_regs[rd_addr_b];
    end
`endif

    // Direct register taps for the operand mux, plus busy.
    always_comb begin
        busy = w_busy;
        q0   = r_regs[0];
        q1   = r_regs[1];
        q2   = r_regs[2];
        q3   = r_regs[3];
        q4   = r_regs[4];
        q5   = r_regs[5];
        q6   = r_regs[6];
        q7   = r_regs[7];
    end

endmodule
